divider_controller: RTL

Sequencing FSM for the unsigned fixed-point divider. It drives the load, clear and shift strobes of shift register A (partial remainder), the quotient register Q and the divisor register B through a restoring-division loop. It reads back two status bits from the datapath: the subtractor sign and the divisor-zero detect. It sits between the top-level start/done handshake and the divider datapath, and it owns the iteration count.

---
 rtl/divider_pkg.sv | 30 +++
 rtl/divider_controller_iter_counter.sv | 40 ++++
 rtl/divider_controller.sv | 125 ++++++++++++
 3 files changed

// File: rtl/divider_pkg.sv
// +----------------------------------------------------------------------------+
// | divider_pkg                                                                |
// | Shared state type and sizing constants for the divider sequencer.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package divider_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_CHECK = 3'd2,
        ST_SHIFT = 3'd3,
        ST_SUB   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam int c_ITERS_DEFAULT = 10;

    // At least one bit so a single-iteration build still has a counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int c_CNT_W = cnt_width(c_ITERS_DEFAULT);

endpackage

`default_nettype wire

// File: rtl/divider_controller_iter_counter.sv
// +----------------------------------------------------------------------------+
// | iter_counter                                                               |
// | Iteration counter that saturates at ITERS-1 and flags the final step.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module iter_counter
    import divider_pkg::*;
#(
    parameter int ITERS = c_ITERS_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int               c_W    = cnt_width(ITERS);
    localparam logic [c_W-1:0]   c_LAST = c_W'(ITERS - 1);
    localparam logic [c_W-1:0]   c_ONE  = c_W'(1);

    logic [c_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != c_LAST)) begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

    assign o_tc = (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/divider_controller.sv
// +----------------------------------------------------------------------------+
// | divider_controller                                                         |
// | Restoring-division sequencer driving the A/Q/B datapath strobes.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module divider_controller
    import divider_pkg::*;
#(
    parameter int ITERS = c_ITERS_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic a_ge_b,
    input  logic dvs_zero,
    output logic ldB,
    output logic ldQ,
    output logic clrA,
    output logic shl,
    output logic ldA,
    output logic setq0,
    output logic busy,
    output logic done,
    output logic err
);

    state_t r_state;
    state_t w_next;
    logic   r_err;
    logic   w_tc;
    logic   w_cnt_clr;
    logic   w_cnt_en;
    logic   w_ld;
    logic   w_clrA;
    logic   w_shl;
    logic   w_ldA;
    logic   w_done;

    iter_counter #(
        .ITERS (ITERS)
    ) u_iter_counter (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_cnt_clr),
        .i_en  (w_cnt_en),
        .o_tc  (w_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((r_state == ST_IDLE) && start) begin
                r_err <= 1'b0;
            end else if ((r_state == ST_CHECK) && dvs_zero) begin
                r_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_cnt_clr = 1'b0;
        w_cnt_en  = 1'b0;
        w_ld      = 1'b0;
        w_clrA    = 1'b0;
        w_shl     = 1'b0;
        w_ldA     = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = ST_INIT;
                end
            end
            ST_INIT: begin
                w_ld      = 1'b1;
                w_clrA    = 1'b1;
                w_cnt_clr = 1'b1;
                w_next    = ST_CHECK;
            end
            ST_CHECK: begin
                w_next = dvs_zero ? ST_DONE : ST_SHIFT;
            end
            ST_SHIFT: begin
                w_shl  = 1'b1;
                w_next = ST_SUB;
            end
            ST_SUB: begin
                // Restore is implicit: A is simply not reloaded when the trial subtract borrows.
                w_ldA = a_ge_b;
                if (w_tc) begin
                    w_next = ST_DONE;
                end else begin
                    w_cnt_en = 1'b1;
                    w_next   = ST_SHIFT;
                end
            end
            ST_DONE: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign ldB   = w_ld;
    assign ldQ   = w_ld;
    assign clrA  = w_clrA;
    assign shl   = w_shl;
    assign ldA   = w_ldA;
    assign setq0 = w_ldA;
    assign busy  = (r_state != ST_IDLE);
    assign done  = w_done;
    assign err   = r_err;

endmodule

`default_nettype wire
